// File: rtl/phase_step_controller.sv
// phase_step_controller
//
// Walks the clock-phase selector toward a requested absolute phase, one step
// at a time, along the shortest path around the ring. A phase difference of
// exactly half the ring resolves to increment. After every step, a
// programmable settle interval gives the delayed clock time to stabilise.
// The settle interval can be frozen with hold.
//
// Parameters:
//   PHASE_W    phase index width; the ring has 2**PHASE_W phases
//   SETTLE_CYC settle cycles after each step (1 .. 2**CNT_W-1)
//   CNT_W      settle counter width
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   req_valid   phase-change request valid
//   req_ready   request can be accepted (IDLE only), registered
//   req_target  absolute target phase, sampled on handshake
//   hold        freezes the settle countdown while high
//   step_en     one-cycle pulse: delay line moves one phase, registered
//   step_dir    1 = increment, 0 = decrement; holds its value outside STEP
//   cur_phase   phase currently applied to the delay line
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse, registered
//   abort       (PHASE_CTRL_ABORT_EN only) ends a walk early from STEP/SETTLE
//   aborted     (PHASE_CTRL_ABORT_EN only) qualifies done for an aborted walk
//
// Optional feature macro: PHASE_CTRL_ABORT_EN
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// STEP   | step_en pulse, cur_phase moves at the end of the cycle
// SETTLE | settle countdown, frozen by hold
// DONE   | done pulse, back to IDLE

module phase_step_controller #(
    parameter int PHASE_W    = 4,
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PHASE_W-1:0] req_target,
    input  logic               hold,
`ifdef PHASE_CTRL_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic               step_en,
    output logic               step_dir,
    output logic [PHASE_W-1:0] cur_phase,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STEP   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [PHASE_W-1:0] HALF      = {1'b1, {(PHASE_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [PHASE_W-1:0] target_q;
    logic [PHASE_W-1:0] tgt_sel;
    logic [PHASE_W-1:0] diff;
    logic               dir_calc;
    logic [CNT_W-1:0]   cnt;
    logic               abort_hit;

`ifdef PHASE_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign busy = (state != S_IDLE);

    // Direction is decided when entering STEP. From IDLE the target is the one
    // being handshaken; from SETTLE, cur_phase already reflects the last step.
    assign tgt_sel  = (state == S_IDLE) ? req_target : target_q;
    assign diff     = tgt_sel - cur_phase;
    assign dir_calc = (diff <= HALF);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt = (req_target == cur_phase) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                state_nxt = abort_hit ? S_DONE : S_SETTLE;
            end
            S_SETTLE: begin
                if (abort_hit) begin
                    state_nxt = S_DONE;
                end else if (!hold && (cnt == '0)) begin
                    state_nxt = (cur_phase == target_q) ? S_DONE : S_STEP;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            target_q  <= '0;
            cur_phase <= '0;
            cnt       <= '0;
            step_en   <= 1'b0;
            step_dir  <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state == S_IDLE) && (state_nxt != S_IDLE)) begin
                target_q <= req_target;
            end

            // A step issued in STEP always lands, even if the walk is aborted.
            if (state == S_STEP) begin
                cur_phase <= step_dir ? (cur_phase + PHASE_W'(1))
                                      : (cur_phase - PHASE_W'(1));
            end

            if (state == S_STEP) begin
                cnt <= SETTLE_LD;
            end else if ((state == S_SETTLE) && !hold && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end

            step_en   <= (state_nxt == S_STEP);
            done      <= (state_nxt == S_DONE);
            req_ready <= (state_nxt == S_IDLE);

            if (state_nxt == S_STEP) begin
                step_dir <= dir_calc;
            end
        end
    end

`ifdef PHASE_CTRL_ABORT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort_hit && ((state == S_STEP) || (state == S_SETTLE));
        end
    end
`endif

endmodule

// File: tb/tb_phase_step_controller.sv
module tb_phase_step_controller;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_target;
    logic       hold;
    logic       step_en;
    logic       step_dir;
    logic [3:0] cur_phase;
    logic       busy;
    logic       done;
`ifdef PHASE_CTRL_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int n_checks;
    int n_fail;

    phase_step_controller #(
        .PHASE_W   (4),
        .SETTLE_CYC(8),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_target(req_target),
        .hold      (hold),
`ifdef PHASE_CTRL_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .step_en   (step_en),
        .step_dir  (step_dir),
        .cur_phase (cur_phase),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] target;
        int         steps;
        bit         dir;
        int         done_cyc;
        logic [3:0] final_ph;
        bit         noise;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request and follow it to done. Step pulses are expected at
    // 1 + 9*j after the handshake, shifted by the hold length once the hold
    // window has started before that pulse.
    task automatic run_req(input string tag, input logic [3:0] tgt,
                           input int exp_steps, input bit exp_dir,
                           input int exp_done, input logic [3:0] exp_final,
                           input bit noise, input int hold_start,
                           input int hold_len);
        int  steps;
        int  done_cyc;
        int  w;
        int  expc;
        bit  quiet;
        logic [3:0] ph;
        steps    = 0;
        done_cyc = -1;
        w        = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready_before"}, int'(req_ready), 1);
        req_valid  = 1'b1;
        req_target = tgt;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (noise) req_target = ~tgt;
                else       req_valid  = 1'b0;
            end
            if (hold_len > 0 && c == hold_start)            hold = 1'b1;
            if (hold_len > 0 && c == hold_start + hold_len) hold = 1'b0;
            if (step_en) begin
                expc = 1 + 9 * steps +
                       ((hold_len > 0 && hold_start < 1 + 9 * steps) ? hold_len : 0);
                check({tag, " step_cycle"}, c, expc);
                check({tag, " step_dir"}, int'(step_dir), int'(exp_dir));
                steps++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        check({tag, " done_cycle"}, done_cyc, exp_done);
        check({tag, " step_count"}, steps, exp_steps);
        check({tag, " final_phase"}, int'(cur_phase), int'(exp_final));
`ifdef PHASE_CTRL_ABORT_EN
        check({tag, " aborted_low"}, int'(aborted), 0);
`endif
        @(negedge clk);
        req_valid = 1'b0;
        hold      = 1'b0;
        check({tag, " ready_after"}, int'(req_ready), 1);
        check({tag, " busy_after"}, int'(busy), 0);
        quiet = 1'b1;
        ph    = cur_phase;
        repeat (3) begin
            @(negedge clk);
            if (step_en || done || busy || cur_phase != exp_final) quiet = 1'b0;
        end
        check({tag, " idle_quiet"}, int'(quiet), 1);
        check({tag, " idle_phase"}, int'(ph), int'(exp_final));
    endtask

    initial begin
        bit saw;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_target = 4'd0;
        hold       = 1'b0;
`ifdef PHASE_CTRL_ABORT_EN
        abort      = 1'b0;
`endif

        //           target steps dir done final noise
        vecs[0] = '{4'd3,  3, 1'b1, 28, 4'd3,  1'b0};
        vecs[1] = '{4'd14, 5, 1'b0, 46, 4'd14, 1'b1};
        vecs[2] = '{4'd6,  8, 1'b1, 73, 4'd6,  1'b0};
        vecs[3] = '{4'd7,  1, 1'b1, 10, 4'd7,  1'b0};
        vecs[4] = '{4'd7,  0, 1'b0,  1, 4'd7,  1'b1};
        vecs[5] = '{4'd0,  7, 1'b0, 64, 4'd0,  1'b0};
        vecs[6] = '{4'd14, 2, 1'b0, 19, 4'd14, 1'b0};

        // Reset state
        #1;
        check("rst cur_phase", int'(cur_phase), 0);
        check("rst req_ready", int'(req_ready), 0);
        check("rst busy_done_step", int'({busy, done, step_en, step_dir}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst req_ready", int'(req_ready), 1);
        check("post_rst cur_phase", int'(cur_phase), 0);

        for (int i = 0; i < 7; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].target, vecs[i].steps,
                    vecs[i].dir, vecs[i].done_cyc, vecs[i].final_ph,
                    vecs[i].noise, 0, 0);
        end

        // Tie with 5 hold cycles during the second settle
        run_req("hold", 4'd6, 8, 1'b1, 78, 4'd6, 1'b0, 12, 5);

        // Reset in the middle of a walk 6 -> 9
        req_valid  = 1'b1;
        req_target = 4'd9;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        check("midrst phase_before", int'(cur_phase), 8);
        #2 reset = 1'b0;
        #1;
        check("midrst cur_phase", int'(cur_phase), 0);
        check("midrst outs", int'({busy, done, step_en, req_ready}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst ready", int'(req_ready), 1);
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || step_en) saw = 1'b1;
        end
        check("midrst no_done", int'(saw), 0);
        check("midrst phase_after", int'(cur_phase), 0);

`ifdef PHASE_CTRL_ABORT_EN
        // Abort in SETTLE after the first step
        req_valid  = 1'b1;
        req_target = 4'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_settle step1", int'(step_en), 1);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_settle done", int'(done), 1);
        check("abort_settle aborted", int'(aborted), 1);
        check("abort_settle phase", int'(cur_phase), 1);
        @(negedge clk);
        check("abort_settle ready", int'(req_ready), 1);

        // Abort during STEP: the issued step still lands
        req_valid  = 1'b1;
        req_target = 4'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_step step", int'(step_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_step done", int'(done), 1);
        check("abort_step aborted", int'(aborted), 1);
        check("abort_step phase", int'(cur_phase), 2);
        @(negedge clk);
        check("abort_step ready", int'(req_ready), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_step_controller.md
Name: phase_step_controller

Overview:
Sequencer for the clock-phasing datapath. Accepts a target phase over a valid/ready handshake and walks the phase selector toward it one step at a time, taking the shortest path with wrap-around. A programmable settle interval follows every step so the delayed clock stabilises before the next move. Sits between the control/config logic and the clock-phasing delay line, which consumes step_en/step_dir.

Parameters:
PHASE_W, 4, phase index width; the ring has N = 2^PHASE_W phases.
SETTLE_CYC, 8, settle cycles after each step; legal range is 1 to 2^CNT_W-1.
CNT_W, 8, settle counter width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
req_valid  in  1  phase-change request valid.
req_ready  out  1  controller can accept a request; high only in IDLE.
req_target  in  PHASE_W  absolute target phase; sampled on handshake.
hold  in  1  freezes the settle countdown while high.
step_en  out  1  one-cycle pulse that tells the delay line to move one phase.
step_dir  out  1  1 = increment phase, 0 = decrement; valid while step_en=1.
cur_phase  out  PHASE_W  phase currently applied to the delay line.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a request completes.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - State returns to IDLE.
  - cur_phase=0, step_en=0, step_dir=0, busy=0, done=0, settle counter=0.
  - req_ready=0 while reset is asserted; it reads 1 from the first cycle after release.
- Reset mid-operation: the request is lost with no done pulse, and cur_phase returns to 0.
- FSM states: IDLE, STEP, SETTLE, DONE.
- IDLE: req_ready=1. A handshake (req_valid & req_ready at a rising edge) latches req_target.
  - If target == cur_phase, go to DONE.
  - Otherwise go to STEP.
- STEP (exactly one cycle): step_en=1 and step_dir is driven.
  - Direction: diff = (target - cur_phase) mod N. step_dir=1 if diff <= N/2, else 0.
  - A tie (diff == N/2) resolves to increment.
  - At the end of the cycle, cur_phase moves by ±1 mod N (15+1 → 0, 0-1 → 15 for PHASE_W=4).
  - Counter loads SETTLE_CYC-1; go to SETTLE.
- SETTLE: the counter decrements each cycle while hold=0 and freezes while hold=1.
  - When counter == 0 and hold == 0, go to DONE if cur_phase == target, else go to STEP.
  - Direction is recomputed on every STEP.
- DONE (one cycle): done=1, then return to IDLE.
- Timing: step_en is never high in two consecutive cycles. Minimum spacing between pulses is SETTLE_CYC+1 cycles.
- Latency with hold=0 and k = min(diff, N-diff) steps:
  - Cycle 1 after the handshake is the first step_en (or done when k=0).
  - done is high in cycle k*(SETTLE_CYC+1)+1 after the handshake.
- While busy: req_valid is ignored and req_target changes have no effect (only the latched target is used).
- step_dir holds its last value outside STEP. step_en, done and req_ready are registered outputs.

Optional Feature:
Macro: PHASE_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit) and output port aborted (1 bit, reset 0).
  - abort=1 in STEP or SETTLE sends the FSM to DONE at the next edge. A step already issued in the STEP cycle still updates cur_phase.
  - In that DONE cycle done=1 and aborted=1 together; aborted is 0 on normal completion.
  - abort is ignored in IDLE and DONE.
- Not defined: neither port exists and the FSM never leaves STEP/SETTLE early.

Test Plan:
All scenarios use PHASE_W=4, SETTLE_CYC=8.
1. Reset: assert reset=0 mid-cycle -> outputs 0 immediately; after release, req_ready=1 and cur_phase=0.
2. cur_phase=0, request target=3 -> 3 step_en pulses with step_dir=1, 9 cycles apart at cycles 1, 10, 19 -> done at cycle 28, cur_phase=3.
3. cur_phase=3, request target=14 (diff=11) -> 5 decrement pulses: 3→2→1→0→15→14 -> done at cycle 46.
4. Target equal to cur_phase=7 -> no step_en, done at cycle 1, req_ready back to 1 at cycle 2. Also: a second req_valid while busy -> not accepted, cur_phase unaffected.
5. Tie: cur_phase=14, target=6 -> 8 increment pulses wrapping 15→0 -> done at cycle 73. Hold=1 for 5 cycles during the 2nd SETTLE -> done at cycle 78.
6. Reset asserted after the 2nd step of scenario 2 -> cur_phase=0, no done pulse. With PHASE_CTRL_ABORT_EN, abort in SETTLE after step 1 -> done=aborted=1 next cycle, cur_phase=1.
